// File: rtl/rd_hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// rd_hazard_scoreboard_pkg
//   Shared hazard definitions for the in-flight register-write tracker and its
//   lookup sub-module.
//   Contents:
//     REG_ZERO   - address of the hardwired-zero register. It is never tracked
//                  and never reported as a hazard.
//     tnew_e     - Tnew/Tuse encodings, counted in cycles from the E stage:
//                  TNEW_E=0, TNEW_M=1, TNEW_W=2.
//     fwd_sel_e  - forward-select encodings at the default depth:
//                  register file, then E, M, W (entry k selects k+1).
// ---------------------------------------------------------------------------
package rd_hazard_scoreboard_pkg;

  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    TNEW_E = 2'd0,
    TNEW_M = 2'd1,
    TNEW_W = 2'd2
  } tnew_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/rd_hazard_scoreboard_lookup.sv
// ---------------------------------------------------------------------------
// hazard_lookup
//   Purely combinational hazard check for one D-stage source operand. It
//   compares the operand against every tracked in-flight write and gives the
//   youngest matching entry priority.
//   Ports:
//     entry_vld  [DEPTH]          valid bit per tracked entry (0 = youngest/E)
//     entry_dst  [DEPTH*ADDR_W]   flattened destination registers
//     entry_tnew [DEPTH*T_W]      flattened cycles-until-forwardable
//     src_addr   [ADDR_W]         source register read in D
//     src_tuse   [T_W]            cycles until D consumes the source
//     hazard     1                result is not ready in time; D must stall
//     fwd_sel    [SEL_W]          0 = register file, k+1 = forward from entry k
// ---------------------------------------------------------------------------
module hazard_lookup
  import rd_hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 5,
  parameter int T_W    = 2,
  parameter int SEL_W  = 2
) (
  input  logic [DEPTH-1:0]        entry_vld,
  input  logic [DEPTH*ADDR_W-1:0] entry_dst,
  input  logic [DEPTH*T_W-1:0]    entry_tnew,
  input  logic [ADDR_W-1:0]       src_addr,
  input  logic [T_W-1:0]          src_tuse,
  output logic                    hazard,
  output logic [SEL_W-1:0]        fwd_sel
);

  logic             hit;
  logic [SEL_W-1:0] hit_sel;
  logic [T_W-1:0]   hit_tnew;

  // The scan runs from oldest to youngest so that later (younger) matches
  // overwrite earlier ones. An older write to the same register is stale
  // whenever a younger one exists.
  always_comb begin
    hit      = 1'b0;
    hit_sel  = SEL_W'(FWD_RF);
    hit_tnew = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (entry_vld[k] && (entry_dst[k*ADDR_W +: ADDR_W] == src_addr)) begin
        hit      = 1'b1;
        hit_sel  = SEL_W'(k + 1);
        hit_tnew = entry_tnew[k*T_W +: T_W];
      end
    end
    if (src_addr == ADDR_W'(REG_ZERO)) begin
      hit = 1'b0;
    end
  end

  assign hazard = hit && (hit_tnew > src_tuse);

  // Forward only when the value already exists (tnew==0). A nonzero tnew
  // that still meets tuse is resolved by the forwarding muxes in a later stage.
  assign fwd_sel = (hit && (hit_tnew == T_W'(TNEW_E))) ? hit_sel : SEL_W'(FWD_RF);

endmodule

// File: rtl/rd_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// rd_hazard_scoreboard
//   In-flight register-write tracker for the pipelined MIPS core. It keeps one
//   entry per post-decode stage (entry0=E ... entry[DEPTH-1]=last stage).
//   Each entry holds valid, destination and cycles-until-result (Tnew). Every
//   cycle the D-stage rs/rt are looked up against all entries. From that the
//   block produces a stall request and per-source forward selects.
//   Optional feature macro: HAZARD_STATS_EN adds a saturating stall-cycle
//   counter on port stall_count. Without it, the port and its logic are absent.
//   Ports:
//     clk          1       rising-edge clock
//     reset        1       asynchronous, active-high; empties all entries
//     issue_valid  1       a real instruction occupies D
//     issue_we     1       D instruction writes issue_rd
//     issue_rd     ADDR_W  D instruction destination
//     issue_tnew   T_W     cycles after entering E until result is forwardable
//     rs_addr/rs_tuse      D source 1 and its consume time
//     rt_addr/rt_tuse      D source 2 and its consume time
//     flush        1       kill every tracked entry at the next edge
//     stall        1       hold PC and D, insert a bubble into E
//     rs_fwd_sel   SEL_W   0=register file, k+1=forward from entry k
//     rt_fwd_sel   SEL_W   same, for rt
//     stall_count  32      (HAZARD_STATS_EN only) stall cycles seen
// ---------------------------------------------------------------------------
module rd_hazard_scoreboard
  import rd_hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 5,
  parameter int T_W    = 2,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [T_W-1:0]    issue_tnew,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [T_W-1:0]    rs_tuse,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [T_W-1:0]    rt_tuse,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  rs_fwd_sel,
  output logic [SEL_W-1:0]  rt_fwd_sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  // Tnew counts down as an entry advances and bottoms out at "ready now".
  function automatic logic [T_W-1:0] dec_sat(input logic [T_W-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

`ifdef HAZARD_STATS_EN
  function automatic logic [31:0] inc_sat(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction
`endif

  logic [DEPTH-1:0]        entry_vld;
  logic [DEPTH*ADDR_W-1:0] entry_dst;
  logic [DEPTH*T_W-1:0]    entry_tnew;

  logic hazard_rs;
  logic hazard_rt;
  logic alloc;

  // ---- D stage: combinational lookup ----
  hazard_lookup #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .T_W   (T_W),
    .SEL_W (SEL_W)
  ) u_lookup_rs (
    .entry_vld (entry_vld),
    .entry_dst (entry_dst),
    .entry_tnew(entry_tnew),
    .src_addr  (rs_addr),
    .src_tuse  (rs_tuse),
    .hazard    (hazard_rs),
    .fwd_sel   (rs_fwd_sel)
  );

  hazard_lookup #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .T_W   (T_W),
    .SEL_W (SEL_W)
  ) u_lookup_rt (
    .entry_vld (entry_vld),
    .entry_dst (entry_dst),
    .entry_tnew(entry_tnew),
    .src_addr  (rt_addr),
    .src_tuse  (rt_tuse),
    .hazard    (hazard_rt),
    .fwd_sel   (rt_fwd_sel)
  );

  assign stall = issue_valid & (hazard_rs | hazard_rt);

  // A stalled instruction stays in D, so E receives a bubble. Writes to the
  // zero register never need tracking.
  assign alloc = issue_valid & ~stall & issue_we & (issue_rd != ADDR_W'(REG_ZERO));

  // ---- D -> E ... -> retire: entry shift register (control) ----
  // Downstream stages never stall, so entries advance on every edge. The
  // last one simply falls off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_vld <= '0;
    end else if (flush) begin
      entry_vld <= '0;
    end else begin
      entry_vld[0] <= alloc;
      for (int k = 1; k < DEPTH; k++) begin
        entry_vld[k] <= entry_vld[k-1];
      end
    end
  end

  // ---- D -> E ... -> retire: entry shift register (data) ----
  // Payload is qualified by entry_vld and needs no reset.
  always_ff @(posedge clk) begin
    entry_dst[ADDR_W-1:0] <= issue_rd;
    entry_tnew[T_W-1:0]   <= issue_tnew;
    for (int k = 1; k < DEPTH; k++) begin
      entry_dst[k*ADDR_W +: ADDR_W] <= entry_dst[(k-1)*ADDR_W +: ADDR_W];
      entry_tnew[k*T_W +: T_W]      <= dec_sat(entry_tnew[(k-1)*T_W +: T_W]);
    end
  end

`ifdef HAZARD_STATS_EN
  // Stall cycles that coincide with a flush are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && !flush) begin
      stall_count <= inc_sat(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_rd_hazard_scoreboard.sv
module tb_rd_hazard_scoreboard;

  localparam int DEPTH  = 3;
  localparam int ADDR_W = 5;
  localparam int T_W    = 2;
  localparam int SEL_W  = 2;
  localparam int NVEC   = 30;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              issue_valid = 1'b0;
  logic              issue_we = 1'b0;
  logic [ADDR_W-1:0] issue_rd = '0;
  logic [T_W-1:0]    issue_tnew = '0;
  logic [ADDR_W-1:0] rs_addr = '0;
  logic [T_W-1:0]    rs_tuse = '0;
  logic [ADDR_W-1:0] rt_addr = '0;
  logic [T_W-1:0]    rt_tuse = '0;
  logic              flush = 1'b0;
  logic              stall;
  logic [SEL_W-1:0]  rs_fwd_sel;
  logic [SEL_W-1:0]  rt_fwd_sel;
`ifdef HAZARD_STATS_EN
  logic [31:0]       stall_count;
`endif

  rd_hazard_scoreboard #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .T_W   (T_W),
    .SEL_W (SEL_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_we   (issue_we),
    .issue_rd   (issue_rd),
    .issue_tnew (issue_tnew),
    .rs_addr    (rs_addr),
    .rs_tuse    (rs_tuse),
    .rt_addr    (rt_addr),
    .rt_tuse    (rt_tuse),
    .flush      (flush),
    .stall      (stall),
    .rs_fwd_sel (rs_fwd_sel),
    .rt_fwd_sel (rt_fwd_sel)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  tn;
    logic [4:0]  rs;
    logic [1:0]  rsu;
    logic [4:0]  rt;
    logic [1:0]  rtu;
    logic        fl;
    logic        e_st;
    logic [1:0]  e_rs;
    logic [1:0]  e_rt;
  } vec_t;

  typedef struct packed {
    logic       st;
    logic [1:0] rs;
    logic [1:0] rt;
  } exp_t;

  vec_t tbl [NVEC];
  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input int v, we, rd, tn, rs, rsu, rt, rtu, fl,
                              st, srs, srt);
    vec_t x;
    x.v    = 1'(v);
    x.we   = 1'(we);
    x.rd   = 5'(rd);
    x.tn   = 2'(tn);
    x.rs   = 5'(rs);
    x.rsu  = 2'(rsu);
    x.rt   = 5'(rt);
    x.rtu  = 2'(rtu);
    x.fl   = 1'(fl);
    x.e_st = 1'(st);
    x.e_rs = 2'(srs);
    x.e_rt = 2'(srt);
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".stall"}, int'(stall), int'(e.st));
      chk({tag, ".rs_sel"}, int'(rs_fwd_sel), int'(e.rs));
      chk({tag, ".rt_sel"}, int'(rt_fwd_sel), int'(e.rt));
    end
  endtask

  task automatic apply(input vec_t x);
    issue_valid = x.v;
    issue_we    = x.we;
    issue_rd    = x.rd;
    issue_tnew  = x.tn;
    rs_addr     = x.rs;
    rs_tuse     = x.rsu;
    rt_addr     = x.rt;
    rt_tuse     = x.rtu;
    flush       = x.fl;
    exp_q.push_back({x.e_st, x.e_rs, x.e_rt});
  endtask

  // Inputs change just after the falling edge; outputs are sampled 2ns later,
  // well before the next rising edge commits the cycle.
  task automatic drive(input vec_t x, input string tag);
    @(negedge clk);
    apply(x);
    #2;
    compare(tag);
  endtask

  initial begin
    // fields: v we rd tnew | rs rs_tuse rt rt_tuse | flush | stall rs_sel rt_sel
    tbl[0]  = mk(0,0, 0,0,  0,0,  0,0, 0, 0,0,0);  // idle after reset
    tbl[1]  = mk(1,1, 8,1,  1,0,  2,0, 0, 0,0,0);  // load $8 (tnew=1)
    tbl[2]  = mk(1,0, 0,0,  8,0,  0,0, 0, 1,0,0);  // use $8 tuse=0: stall
    tbl[3]  = mk(1,1,10,0,  8,0,  0,0, 0, 0,2,0);  // replay: forward from M
    tbl[4]  = mk(1,0, 0,0, 10,0,  8,1, 0, 0,1,3);  // $10 from E, $8 from W
    tbl[5]  = mk(0,0, 0,0,  8,0, 10,0, 0, 0,0,2);  // $8 retired, $10 in M
    tbl[6]  = mk(0,0, 0,0, 10,0,  0,0, 0, 0,3,0);  // $10 in W
    tbl[7]  = mk(1,1, 8,0,  0,0,  0,0, 0, 0,0,0);  // addu $8
    tbl[8]  = mk(1,1, 8,0,  8,0,  0,0, 0, 0,1,0);  // addu $8 again
    tbl[9]  = mk(1,0, 0,0,  8,0,  8,1, 0, 0,1,1);  // youngest (E) wins
    tbl[10] = mk(0,0, 0,0,  8,0,  0,0, 0, 0,2,0);  // younger now in M
    tbl[11] = mk(0,0, 0,0,  8,0,  0,0, 0, 0,3,0);  // W, tnew held at 0
    tbl[12] = mk(1,1, 0,2,  0,0,  0,0, 0, 0,0,0);  // write $0: not tracked
    tbl[13] = mk(1,0, 0,0,  0,0,  0,0, 0, 0,0,0);  // read $0: no hazard
    tbl[14] = mk(1,1,11,2,  0,0,  0,0, 0, 0,0,0);  // $11 tnew=2
    tbl[15] = mk(1,0, 0,0, 11,2,  0,0, 0, 0,0,0);  // tnew==tuse: no stall
    tbl[16] = mk(1,0, 0,0, 11,1, 11,0, 0, 1,0,0);  // rt side hazards
    tbl[17] = mk(1,0, 0,0, 11,1, 11,0, 0, 0,3,3);  // both from W
    tbl[18] = mk(1,1,12,2,  0,0,  0,0, 0, 0,0,0);  // $12 tnew=2
    tbl[19] = mk(0,0, 0,0, 12,0,  0,0, 0, 0,0,0);  // hazard w/o valid: no stall
    tbl[20] = mk(1,1,13,0, 12,0,  0,0, 0, 1,0,0);  // stall blocks $13 alloc
    tbl[21] = mk(1,0, 0,0, 13,0, 12,0, 0, 0,0,3);  // $13 absent
    tbl[22] = mk(1,1, 9,1,  0,0,  0,0, 0, 0,0,0);  // load $9
    tbl[23] = mk(0,0, 0,0,  0,0,  0,0, 1, 0,0,0);  // flush
    tbl[24] = mk(1,0, 0,0,  9,0,  0,0, 0, 0,0,0);  // $9 gone
    tbl[25] = mk(1,1,14,0,  0,0,  0,0, 1, 0,0,0);  // issue with flush
    tbl[26] = mk(1,0, 0,0, 14,0,  0,0, 0, 0,0,0);  // $14 not allocated
    tbl[27] = mk(1,1,15,1,  0,0,  0,0, 0, 0,0,0);  // load $15
    tbl[28] = mk(1,0, 0,0, 15,0,  0,0, 1, 1,0,0);  // stall under flush
    tbl[29] = mk(1,0, 0,0, 15,0,  0,0, 0, 0,0,0);  // $15 flushed

    // Reset state
    @(negedge clk);
    #2;
    chk("reset.stall", int'(stall), 0);
    chk("reset.rs_sel", int'(rs_fwd_sel), 0);
    chk("reset.rt_sel", int'(rt_fwd_sel), 0);
`ifdef HAZARD_STATS_EN
    chk("reset.stall_count", int'(stall_count), 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i], $sformatf("row%0d", i));
    end

`ifdef HAZARD_STATS_EN
    // Non-flushed stalls in the table: rows 2, 16, 20.
    @(negedge clk);
    chk("stats.count", int'(stall_count), 3);
`endif

    // Reset mid-run with three valid entries and an active stall
    drive(mk(1,1,5,0, 0,0, 0,0, 0, 0,0,0), "rst.fill0");
    drive(mk(1,1,6,0, 5,0, 0,0, 0, 0,1,0), "rst.fill1");
    drive(mk(1,1,7,2, 5,0, 6,0, 0, 0,2,1), "rst.fill2");
    drive(mk(1,0,0,0, 7,0, 6,0, 0, 1,0,2), "rst.pre");
    #1;
    reset = 1'b1;
    exp_q.push_back('{st: 1'b0, rs: 2'd0, rt: 2'd0});
    #1;
    compare("rst.async");
`ifdef HAZARD_STATS_EN
    chk("rst.stall_count", int'(stall_count), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back('{st: 1'b0, rs: 2'd0, rt: 2'd0});
    #2;
    compare("rst.release");
    drive(mk(1,0,0,0, 5,0, 7,0, 0, 0,0,0), "rst.empty");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard.drain: got %0d entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
